// File: rtl/uart_rx_baud_ctrl.sv
// Auto-baud controller: hunts the five UART rates for a clean SYNC_BYTE stream, locks,
// then forwards bytes through a one-entry valid/ready register. Optional stats: UART_BAUD_STAT_EN.
module uart_rx_baud_ctrl #(
   parameter logic [7:0]  SYNC_BYTE   = 8'h55,
   parameter int unsigned LOCK_CNT    = 4,
   parameter int unsigned ERR_MAX     = 3,
   parameter logic [15:0] SETTLE_CYC  = 16'd4096,
   parameter logic [23:0] TIMEOUT_CYC = 24'd2000000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] rx_data_i,
   input  logic       rx_done_i,
   input  logic       rx_error_i,
   input  logic       force_hunt_i,
   input  logic       data_ready_i,
   output logic [2:0] buad_set_o,
   output logic       locked_o,
   output logic [7:0] data_o,
   output logic       data_valid_o,
   output logic       overrun_o
`ifdef UART_BAUD_STAT_EN
   ,
   output logic [15:0] err_total_o,
   output logic [7:0]  relock_cnt_o
`endif
);

   typedef enum logic [1:0] {
      ST_SETTLE = 2'd0,
      ST_HUNT   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [15:0] SETTLE_LOAD  = SETTLE_CYC - 16'd1;
   localparam logic [23:0] TIMEOUT_LOAD = TIMEOUT_CYC - 24'd1;
   localparam logic [3:0]  LOCK_TGT     = 4'(LOCK_CNT);
   localparam logic [3:0]  ERR_TGT      = 4'(ERR_MAX);
   localparam logic [2:0]  RATE_FIRST   = 3'd1;
   localparam logic [2:0]  RATE_LAST    = 3'd5;

   state_t      state_q, state_d;
   logic [15:0] settle_q, settle_d;
   logic [23:0] timeout_q, timeout_d;
   logic [3:0]  good_q, good_d;
   logic [3:0]  err_cnt_q, err_cnt_d;
   logic [2:0]  baud_q, baud_d;
   logic        err_prev_q;
   logic        err_evt;
   logic        advance;
   logic        byte_load;
   logic [3:0]  good_inc;
   logic [3:0]  err_inc;

   function automatic logic [2:0] next_rate(input logic [2:0] rate);
      return (rate >= RATE_LAST) ? RATE_FIRST : rate + 3'd1;
   endfunction

   // A level error that lasts several cycles must count as a single event.
   assign err_evt   = rx_error_i & ~err_prev_q;
   assign good_inc  = good_q + 4'd1;
   assign err_inc   = err_cnt_q + 4'd1;
   assign byte_load = (state_q == ST_LOCKED) & rx_done_i & ~err_evt;

   // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      timeout_d = timeout_q;
      good_d    = good_q;
      err_cnt_d = err_cnt_q;
      baud_d    = baud_q;
      advance   = 1'b0;

      unique case (state_q)
         ST_SETTLE: begin
            if (settle_q == 16'd0) begin
               state_d   = ST_HUNT;
               timeout_d = TIMEOUT_LOAD;
               good_d    = 4'd0;
            end else begin
               settle_d = settle_q - 16'd1;
            end
         end

         ST_HUNT: begin
            if (err_evt) begin
               advance = 1'b1;
            end else if (rx_done_i) begin
               if (rx_data_i == SYNC_BYTE) begin
                  good_d    = good_inc;
                  timeout_d = TIMEOUT_LOAD;
                  if (good_inc == LOCK_TGT) begin
                     state_d   = ST_LOCKED;
                     err_cnt_d = 4'd0;
                  end
               end else begin
                  advance = 1'b1;
               end
            end else if (timeout_q == 24'd0) begin
               advance = 1'b1;
            end else begin
               timeout_d = timeout_q - 24'd1;
            end
         end

         ST_LOCKED: begin
            if (err_evt) begin
               err_cnt_d = err_inc;
               if (err_inc == ERR_TGT) begin
                  advance = 1'b1;
               end
            end else if (rx_done_i) begin
               err_cnt_d = 4'd0;
            end
         end

         default: begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_LOAD;
         end
      endcase

      // The rate only ever changes together with a fresh settle window.
      if (advance) begin
         baud_d   = next_rate(baud_q);
         state_d  = ST_SETTLE;
         settle_d = SETTLE_LOAD;
      end

      if (force_hunt_i) begin
         baud_d   = RATE_FIRST;
         state_d  = ST_SETTLE;
         settle_d = SETTLE_LOAD;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_SETTLE;
         settle_q   <= SETTLE_LOAD;
         timeout_q  <= TIMEOUT_LOAD;
         good_q     <= 4'd0;
         err_cnt_q  <= 4'd0;
         baud_q     <= RATE_FIRST;
         err_prev_q <= 1'b0;
         locked_o   <= 1'b0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         timeout_q  <= timeout_d;
         good_q     <= good_d;
         err_cnt_q  <= err_cnt_d;
         baud_q     <= baud_d;
         err_prev_q <= rx_error_i;
         locked_o   <= (state_d == ST_LOCKED);
      end
   end

   assign buad_set_o = baud_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_o       <= 8'd0;
         data_valid_o <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         overrun_o <= 1'b0;
         if (state_d != ST_LOCKED) begin
            data_valid_o <= 1'b0;
         end else if (byte_load) begin
            if (data_valid_o && !data_ready_i) begin
               overrun_o <= 1'b1;
            end else begin
               data_o       <= rx_data_i;
               data_valid_o <= 1'b1;
            end
         end else if (data_valid_o && data_ready_i) begin
            data_valid_o <= 1'b0;
         end
      end
   end

`ifdef UART_BAUD_STAT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_total_o  <= 16'd0;
         relock_cnt_o <= 8'd0;
      end else begin
         if (err_evt && (err_total_o != 16'hFFFF)) begin
            err_total_o <= err_total_o + 16'd1;
         end
         if ((state_q != ST_LOCKED) && (state_d == ST_LOCKED) && (relock_cnt_o != 8'hFF)) begin
            relock_cnt_o <= relock_cnt_o + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx_baud_ctrl.sv
// Directed bench for uart_rx_baud_ctrl with short settle/timeout windows; a per-cycle
// vector table covers the locked data path, hand sequences cover hunting and reset.
module tb_uart_rx_baud_ctrl;

   localparam int SETTLE = 8;
   localparam int TMO    = 40;
   localparam logic [7:0] SYNC = 8'h55;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [7:0] rx_data_i;
   logic       rx_done_i;
   logic       rx_error_i;
   logic       force_hunt_i;
   logic       data_ready_i;
   logic [2:0] buad_set_o;
   logic       locked_o;
   logic [7:0] data_o;
   logic       data_valid_o;
   logic       overrun_o;
`ifdef UART_BAUD_STAT_EN
   logic [15:0] err_total_o;
   logic [7:0]  relock_cnt_o;
`endif

   int checks   = 0;
   int failures = 0;

   uart_rx_baud_ctrl #(
      .SYNC_BYTE   (SYNC),
      .LOCK_CNT    (4),
      .ERR_MAX     (3),
      .SETTLE_CYC  (16'(SETTLE)),
      .TIMEOUT_CYC (24'(TMO))
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rx_data_i    (rx_data_i),
      .rx_done_i    (rx_done_i),
      .rx_error_i   (rx_error_i),
      .force_hunt_i (force_hunt_i),
      .data_ready_i (data_ready_i),
      .buad_set_o   (buad_set_o),
      .locked_o     (locked_o),
      .data_o       (data_o),
      .data_valid_o (data_valid_o),
      .overrun_o    (overrun_o)
`ifdef UART_BAUD_STAT_EN
      ,
      .err_total_o  (err_total_o),
      .relock_cnt_o (relock_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [7:0] d;
      logic       done;
      logic       err;
      logic       rdy;
      logic [2:0] e_baud;
      logic       e_lock;
      logic [7:0] e_data;
      logic       e_valid;
      logic       e_ov;
   } vec_t;

   vec_t vt [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [2:0] baud, input logic lk,
                            input logic [7:0] d, input logic v, input logic ov);
      check({name, "_baud"},    32'(buad_set_o),   32'(baud));
      check({name, "_locked"},  32'(locked_o),     32'(lk));
      check({name, "_data"},    32'(data_o),       32'(d));
      check({name, "_valid"},   32'(data_valid_o), 32'(v));
      check({name, "_overrun"}, 32'(overrun_o),    32'(ov));
   endtask

   // Inputs change 1 time unit after a rising edge, outputs are sampled there too.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input logic [7:0] b);
      rx_data_i = b;
      rx_done_i = 1'b1;
      tick();
      rx_done_i = 1'b0;
   endtask

   task automatic err_pulse();
      rx_error_i = 1'b1;
      tick();
      rx_error_i = 1'b0;
   endtask

   task automatic lock_syncs();
      repeat (4) begin
         send(SYNC);
         idle(2);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within the time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0]  = '{8'hA1, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 8'hA1, 1'b1, 1'b0};
      vt[1]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 8'hA1, 1'b0, 1'b0};
      vt[2]  = '{8'hB2, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 8'hB2, 1'b1, 1'b0};
      vt[3]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 8'hB2, 1'b0, 1'b0};
      vt[4]  = '{8'h11, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h11, 1'b1, 1'b0};
      vt[5]  = '{8'h22, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h11, 1'b1, 1'b1};
      vt[6]  = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'h11, 1'b1, 1'b0};
      vt[7]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 8'h11, 1'b0, 1'b0};
      vt[8]  = '{8'h33, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h33, 1'b1, 1'b0};
      vt[9]  = '{8'h44, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 8'h44, 1'b1, 1'b0};
      vt[10] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'h44, 1'b1, 1'b0};
      vt[11] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 8'h44, 1'b1, 1'b0};
      vt[12] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'h44, 1'b1, 1'b0};
      vt[13] = '{8'h55, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, 8'h44, 1'b1, 1'b0};
      vt[14] = '{8'h66, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 8'h66, 1'b1, 1'b0};
      vt[15] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 8'h66, 1'b1, 1'b0};
      vt[16] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'h66, 1'b1, 1'b0};
      vt[17] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 8'h66, 1'b1, 1'b0};
      vt[18] = '{8'h00, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'h66, 1'b1, 1'b0};
      vt[19] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 8'h66, 1'b0, 1'b0};

      rst_i        = 1'b1;
      rx_data_i    = 8'h00;
      rx_done_i    = 1'b0;
      rx_error_i   = 1'b0;
      force_hunt_i = 1'b0;
      data_ready_i = 1'b0;
      #1;
      check_all("reset", 3'd1, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef UART_BAUD_STAT_EN
      check("reset_err_total", 32'(err_total_o), 32'd0);
      check("reset_relock", 32'(relock_cnt_o), 32'd0);
`endif
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;

      // Settle window after reset: a wrong byte is ignored, then HUNT times out 1 -> 2.
      send(8'h00);
      idle(SETTLE - 2);
      check("settle_ignore_baud", 32'(buad_set_o), 32'd1);
      tick();
      idle(TMO - 1);
      check("timeout_edge_minus1", 32'(buad_set_o), 32'd1);
      tick();
      check("timeout_advance_1to2", 32'(buad_set_o), 32'd2);

      // Rate 2: mismatched byte advances; rate 3: four sync bytes lock.
      idle(SETTLE);
      send(8'hD5);
      check("mismatch_advance_2to3", 32'(buad_set_o), 32'd3);
      idle(SETTLE);
      repeat (3) begin
         send(SYNC);
         idle(2);
      end
      check("three_sync_not_locked", 32'(locked_o), 32'd0);
      send(SYNC);
      check_all("locked_rate3", 3'd3, 1'b1, 8'h00, 1'b0, 1'b0);
      idle(TMO + 20);
      check("locked_no_timeout_lock", 32'(locked_o), 32'd1);
      check("locked_no_timeout_baud", 32'(buad_set_o), 32'd3);

      for (int i = 0; i < 20; i++) begin
         rx_data_i    = vt[i].d;
         rx_done_i    = vt[i].done;
         rx_error_i   = vt[i].err;
         data_ready_i = vt[i].rdy;
         tick();
         check_all($sformatf("vec%0d", i), vt[i].e_baud, vt[i].e_lock, vt[i].e_data,
                   vt[i].e_valid, vt[i].e_ov);
      end
      rx_done_i    = 1'b0;
      rx_error_i   = 1'b0;
      data_ready_i = 1'b0;

      // Rate 4 HUNT: simultaneous sync byte and error edge counts as an error.
      idle(SETTLE);
      rx_data_i  = SYNC;
      rx_done_i  = 1'b1;
      rx_error_i = 1'b1;
      tick();
      rx_done_i  = 1'b0;
      rx_error_i = 1'b0;
      check("done_err_same_cycle_baud", 32'(buad_set_o), 32'd5);
      check("done_err_same_cycle_lock", 32'(locked_o), 32'd0);

      // Rate 5 HUNT timeout wraps to rate 1.
      idle(SETTLE);
      idle(TMO - 1);
      check("wrap_edge_minus1", 32'(buad_set_o), 32'd5);
      tick();
      check("wrap_5to1", 32'(buad_set_o), 32'd1);

      // Walk up to rate 4 on errors, lock, then force a re-hunt.
      idle(SETTLE);
      err_pulse();
      check("err_advance_1to2", 32'(buad_set_o), 32'd2);
      idle(SETTLE);
      err_pulse();
      idle(SETTLE);
      err_pulse();
      check("err_advance_3to4", 32'(buad_set_o), 32'd4);
      idle(SETTLE);
      lock_syncs();
      check("locked_rate4", 32'(locked_o), 32'd1);
      send(8'h77);
      check_all("rate4_byte", 3'd4, 1'b1, 8'h77, 1'b1, 1'b0);
      force_hunt_i = 1'b1;
      tick();
      force_hunt_i = 1'b0;
      check_all("force_hunt", 3'd1, 1'b0, 8'h77, 1'b0, 1'b0);

      // Lock at rate 2 with a pending byte, then reset mid-frame.
      idle(SETTLE);
      err_pulse();
      idle(SETTLE);
      lock_syncs();
      send(8'h9C);
      check_all("rate2_byte", 3'd2, 1'b1, 8'h9C, 1'b1, 1'b0);
`ifdef UART_BAUD_STAT_EN
      check("stat_relock", 32'(relock_cnt_o), 32'd3);
`endif
      rx_data_i = 8'hAA;
      rx_done_i = 1'b1;
      #2;
      rst_i = 1'b1;
      #1;
      check_all("async_reset", 3'd1, 1'b0, 8'h00, 1'b0, 1'b0);
      @(posedge clk_i);
      #1;
      rst_i     = 1'b0;
      rx_done_i = 1'b0;
      tick();
      check_all("after_reset", 3'd1, 1'b0, 8'h00, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_baud_ctrl.md
Name: uart_rx_baud_ctrl

Overview:
- Auto-baud controller for the UART receiver.
- Drives the receiver's baud select and watches its done/error/data outputs.
- Hunts through the five supported rates until a stream of SYNC_BYTE frames decodes cleanly, then locks.
- Once locked, forwards received bytes through a one-entry valid/ready holding register; drops back to hunting after repeated frame errors.

Parameters:
SYNC_BYTE, 8'h55, byte value the host sends to train the rate
LOCK_CNT, 4, consecutive good SYNC_BYTE frames needed to lock (1..15)
ERR_MAX, 3, consecutive frame errors in LOCKED that force re-hunt (1..15)
SETTLE_CYC, 16'd4096, clk_i cycles ignored after every rate change (>=1)
TIMEOUT_CYC, 24'd2000000, clk_i cycles without a good SYNC_BYTE before advancing rate in HUNT (>=1)

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous, active-high reset
rx_data_i  input  8  receiver byte, valid in the cycle rx_done_i=1
rx_done_i  input  1  receiver one-cycle frame-complete pulse
rx_error_i  input  1  receiver frame-error flag (level, may last several cycles)
force_hunt_i  input  1  one-cycle request to drop lock and restart hunting at rate 1
data_ready_i  input  1  downstream ready
buad_set_o  output  3  baud select to receiver: 1=9600, 2=19200, 3=38400, 4=57600, 5=115200
locked_o  output  1  high while in LOCKED
data_o  output  8  forwarded byte
data_valid_o  output  1  data_o valid
overrun_o  output  1  one-cycle pulse when a locked byte is dropped

Behaviour:
- Reset values: buad_set_o=1, locked_o=0, data_o=0, data_valid_o=0, overrun_o=0. State=SETTLE. Settle counter=SETTLE_CYC-1. good_cnt=0, err_cnt=0.
- Reset is honoured in any state, mid-frame included.
- err_evt = rising edge of rx_error_i, detected with one register (reset value 0).
- In any cycle, err_evt takes priority over rx_done_i.
- States: SETTLE, HUNT, LOCKED.
- SETTLE:
  - Count down to 0, ignoring rx_done_i and err_evt.
  - At 0: go to HUNT. Timeout counter=TIMEOUT_CYC-1, good_cnt=0.
- HUNT:
  - rx_done_i with rx_data_i==SYNC_BYTE: good_cnt+1 and reload the timeout counter.
  - If the increment reaches LOCK_CNT: go to LOCKED, err_cnt=0. locked_o=1 from the next cycle.
  - Any of the following advances the rate: err_evt; rx_done_i with any other byte; timeout counter reaching 0.
  - Advancing the rate: buad_set_o = next rate (1→2→3→4→5→1, wrap), then go to SETTLE.
- LOCKED:
  - rx_done_i without err_evt: load the byte and clear err_cnt.
  - err_evt: err_cnt+1. If it reaches ERR_MAX, advance the rate and go to SETTLE.
  - Byte latency: rx_done_i in cycle N gives data_o/data_valid_o in cycle N+1.
- Holding register:
  - data_valid_o clears on data_valid_o & data_ready_i.
  - New byte arriving in the same cycle as a handshake: load it, data_valid_o stays 1.
  - New byte while data_valid_o=1 and data_ready_i=0: discard it, keep data_o, overrun_o=1 next cycle.
  - Leaving LOCKED flushes the register: data_valid_o=0 next cycle.
- force_hunt_i: from any state, buad_set_o=1 and go to SETTLE. This has priority over every other transition.
- locked_o is registered and equals (state==LOCKED).
- buad_set_o only changes on SETTLE entry, so the receiver sees a stable value for at least SETTLE_CYC cycles.

Optional Feature:
UART_BAUD_STAT_EN
- Defined: adds outputs err_total_o[15:0] and relock_cnt_o[7:0], both reset to 0 and saturating.
  - err_total_o counts every err_evt in any state.
  - relock_cnt_o counts entries into LOCKED.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Reset, receiver set to 38400, host sends 0x55 ×6 → buad_set_o steps 1→2→3 via err/mismatch/timeout; locked_o=1 after the 4th good 0x55 at rate 3; buad_set_o stays 3.
- Locked at rate 5, data_ready_i=1, bytes 0xA1, 0xB2 → data_o=0xA1 then 0xB2, each with data_valid_o one cycle after rx_done_i; overrun_o never set.
- Locked, data_ready_i=0, bytes 0x11, 0x22 → data_o holds 0x11, data_valid_o=1, overrun_o one-cycle pulse on 0x22; ready=1 then gives one handshake of 0x11.
- Locked at rate 2, three rx_error_i pulses with no good byte between → on the 3rd, locked_o=0, data_valid_o=0, buad_set_o=3, SETTLE for 4096 cycles. A good byte between errors 2 and 3 keeps the lock.
- HUNT at rate 5 with no traffic for 2,000,000 cycles → buad_set_o wraps 5→1. Same-cycle rx_done_i (0x55) and err_evt → treated as error, rate advances.
- force_hunt_i while locked at rate 4 → buad_set_o=1, locked_o=0 next cycle. rst_i asserted mid-frame → all outputs return to reset values immediately.
